div_arbiter: RTL and testbench

DIV_ARBITER -- requirements
Module: div_arbiter

---
 rtl/div_arbiter.sv | 141 ++++++++++++++
 tb/tb_div_arbiter.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_arbiter.sv
// Round-robin arbiter granting four requesters access to one shared 16-bit divider.
// Latency: Ack 1 cycle after grant; Resp_Valid 1 cycle after Div_Done falls (1 cycle after grant on zero divisor).
// Backpressure: Req is a level held until Ack; one operation in flight, other requests wait in IDLE.
module div_arbiter #(
    parameter int TIMEOUT = 64
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [3:0]  Req,
    input  logic [63:0] Req_Dividend,
    input  logic [63:0] Req_Divisor,
    output logic [3:0]  Ack,
    output logic [3:0]  Resp_Valid,
    output logic [15:0] Resp_Quotient,
    output logic [15:0] Resp_Remainder,
    output logic        Resp_Err,
    output logic        Busy,
    output logic        Div_Start,
    output logic [15:0] Div_Dividend,
    output logic [15:0] Div_Divisor,
    input  logic [15:0] Div_Quotient,
    input  logic [15:0] Div_Remainder,
    input  logic        Div_Done
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ISSUE   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;
    localparam logic [1:0] RESPOND = 2'd3;

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [1:0]       ptr;
    logic [1:0]       owner;
    logic [1:0]       gnt_idx;
    logic [1:0]       scan_idx;
    logic             gnt_found;
    logic [CNT_W-1:0] tmo_cnt;
    logic [15:0]      opa;
    logic [15:0]      opb;
    logic [15:0]      sel_dvd;
    logic [15:0]      sel_dvs;
    logic [15:0]      stage_q;
    logic [15:0]      stage_r;
    logic             stage_err;
    logic [3:0]       ack_q;

    // Scan from the highest offset down so the requester nearest Ptr wins.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = ptr;
        scan_idx  = ptr;
        for (int k = 3; k >= 0; k--) begin
            scan_idx = ptr + 2'(k);
            if (Req[scan_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = scan_idx;
            end
        end
    end

    assign sel_dvd = Req_Dividend[{gnt_idx, 4'b0000} +: 16];
    assign sel_dvs = Req_Divisor[{gnt_idx, 4'b0000} +: 16];

    always_ff @(posedge Clock) begin
        if (!Reset) begin
            state          <= IDLE;
            ptr            <= 2'd0;
            owner          <= 2'd0;
            tmo_cnt        <= '0;
            opa            <= 16'd0;
            opb            <= 16'd0;
            stage_q        <= 16'd0;
            stage_r        <= 16'd0;
            stage_err      <= 1'b0;
            ack_q          <= 4'd0;
            Resp_Quotient  <= 16'd0;
            Resp_Remainder <= 16'd0;
            Resp_Err       <= 1'b0;
        end else begin
            ack_q <= 4'd0;
            case (state)
                IDLE: begin
                    if (gnt_found) begin
                        owner   <= gnt_idx;
                        opa     <= sel_dvd;
                        opb     <= sel_dvs;
                        ack_q   <= 4'b0001 << gnt_idx;
                        tmo_cnt <= '0;
                        if (sel_dvs == 16'd0) begin
                            Resp_Quotient  <= 16'd0;
                            Resp_Remainder <= sel_dvd;
                            Resp_Err       <= 1'b1;
                            state          <= RESPOND;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (Div_Done) begin
                        stage_q   <= Div_Quotient;
                        stage_r   <= Div_Remainder;
                        stage_err <= 1'b0;
                        state     <= RELEASE;
                    end else if (tmo_cnt == CNT_LAST) begin
                        stage_err <= 1'b1;
                        state     <= RELEASE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                RELEASE: begin
                    // Outputs change only on entry to RESPOND; a timeout keeps the old result.
                    if (!Div_Done) begin
                        Resp_Err <= stage_err;
                        if (!stage_err) begin
                            Resp_Quotient  <= stage_q;
                            Resp_Remainder <= stage_r;
                        end
                        state <= RESPOND;
                    end
                end
                default: begin
                    ptr   <= owner + 2'd1;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign Ack          = ack_q;
    assign Resp_Valid   = (state == RESPOND) ? (4'b0001 << owner) : 4'd0;
    assign Busy         = (state != IDLE);
    assign Div_Start    = (state == ISSUE);
    assign Div_Dividend = opa;
    assign Div_Divisor  = opb;

endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: behavioural divider stub plus expected-response scoreboard.
module tb_div_arbiter;

    typedef struct packed {
        logic [3:0]  vld;
        logic [15:0] q;
        logic [15:0] r;
        logic        err;
    } resp_t;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [3:0]  Req = 4'd0;
    logic [63:0] Req_Dividend = 64'd0;
    logic [63:0] Req_Divisor = 64'd0;
    logic [3:0]  Ack;
    logic [3:0]  Resp_Valid;
    logic [15:0] Resp_Quotient;
    logic [15:0] Resp_Remainder;
    logic        Resp_Err;
    logic        Busy;
    logic        Div_Start;
    logic [15:0] Div_Dividend;
    logic [15:0] Div_Divisor;
    logic [15:0] Div_Quotient;
    logic [15:0] Div_Remainder;
    logic        Div_Done;

    int n_vec = 0;
    int n_err = 0;
    int start_cycles = 0;

    resp_t      exp_q[$];
    resp_t      obs_q[$];
    logic [3:0] exp_ack[$];
    logic [3:0] obs_ack[$];

    div_arbiter #(.TIMEOUT(8)) dut (
        .Clock(Clock), .Reset(Reset), .Req(Req),
        .Req_Dividend(Req_Dividend), .Req_Divisor(Req_Divisor),
        .Ack(Ack), .Resp_Valid(Resp_Valid),
        .Resp_Quotient(Resp_Quotient), .Resp_Remainder(Resp_Remainder),
        .Resp_Err(Resp_Err), .Busy(Busy), .Div_Start(Div_Start),
        .Div_Dividend(Div_Dividend), .Div_Divisor(Div_Divisor),
        .Div_Quotient(Div_Quotient), .Div_Remainder(Div_Remainder),
        .Div_Done(Div_Done)
    );

    always #5 Clock = ~Clock;

    // Divider stub: done after stub_lat+1 cycles of Div_Start, held until Div_Start drops.
    logic        stub_done = 1'b0;
    logic [15:0] stub_q = 16'd0;
    logic [15:0] stub_r = 16'd0;
    int          stub_cnt = 0;
    int          stub_lat = 2;
    bit          never_done = 1'b0;

    always @(posedge Clock) begin
        if (!Reset || !Div_Start) begin
            stub_done <= 1'b0;
            stub_cnt  <= 0;
        end else if (!never_done && !stub_done) begin
            if (stub_cnt == stub_lat) begin
                stub_done <= 1'b1;
                stub_q    <= (Div_Divisor == 16'd0) ? 16'd0 : 16'($signed(Div_Dividend) / $signed(Div_Divisor));
                stub_r    <= (Div_Divisor == 16'd0) ? 16'd0 : 16'($signed(Div_Dividend) % $signed(Div_Divisor));
            end else begin
                stub_cnt <= stub_cnt + 1;
            end
        end
    end

    assign Div_Done      = stub_done;
    assign Div_Quotient  = stub_q;
    assign Div_Remainder = stub_r;

    task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
        Req_Dividend[i*16 +: 16] = a;
        Req_Divisor[i*16 +: 16]  = b;
    endtask

    task automatic expect_resp(input logic [3:0] v, input logic [15:0] q, input logic [15:0] r, input logic e);
        resp_t x;
        x.vld = v; x.q = q; x.r = r; x.err = e;
        exp_q.push_back(x);
        exp_ack.push_back(v);
    endtask

    // Steps cycles recording Ack/Resp activity; each requester drops Req on its Ack.
    task automatic collect(input int nresp, input int maxc);
        int seen = 0;
        resp_t x;
        start_cycles = 0;
        for (int c = 0; c < maxc && seen < nresp; c++) begin
            @(negedge Clock);
            if (Div_Start) start_cycles++;
            if (Ack != 4'd0) begin
                obs_ack.push_back(Ack);
                Req = Req & ~Ack;
            end
            if (Resp_Valid != 4'd0) begin
                x.vld = Resp_Valid; x.q = Resp_Quotient; x.r = Resp_Remainder; x.err = Resp_Err;
                obs_q.push_back(x);
                seen++;
            end
        end
    endtask

    task automatic reset_dut();
        @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        repeat (2) @(negedge Clock);
        n_vec++; if (Ack !== 4'd0) begin n_err++; $display("FAIL reset_ack got %b want 0000", Ack); end
        n_vec++; if (Resp_Valid !== 4'd0) begin n_err++; $display("FAIL reset_resp_valid got %b want 0000", Resp_Valid); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", Busy); end
        n_vec++; if (Div_Start !== 1'b0) begin n_err++; $display("FAIL reset_div_start got %b want 0", Div_Start); end
        n_vec++; if ({Resp_Quotient, Resp_Remainder, Resp_Err} !== 33'd0) begin
            n_err++; $display("FAIL reset_result got q=%h r=%h e=%b want 0", Resp_Quotient, Resp_Remainder, Resp_Err);
        end
        n_vec++; if ({Div_Dividend, Div_Divisor} !== 32'd0) begin
            n_err++; $display("FAIL reset_operands got %h/%h want 0", Div_Dividend, Div_Divisor);
        end
        Reset = 1'b1;
    endtask

    task automatic test_single();
        resp_t e, o;
        logic [3:0] ea, oa;
        set_op(0, 16'd100, 16'd7);
        expect_resp(4'b0001, 16'd14, 16'd2, 1'b0);
        Req = 4'b0001;
        collect(1, 100);
        @(negedge Clock);
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL single_idle busy got %b want 0", Busy); end
        n_vec++; if (obs_ack.size() != 1) begin n_err++; $display("FAIL single_ack_count got %0d want 1", obs_ack.size()); end
        while (exp_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = (obs_ack.size() > 0) ? obs_ack.pop_front() : 4'bxxxx;
            n_vec++; if (oa !== ea) begin n_err++; $display("FAIL single_ack got %b want %b", oa, ea); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL single_resp got %h want %h", o, e); end
        end
        obs_ack.delete(); obs_q.delete();
    endtask

    task automatic test_signed();
        resp_t e, o;
        set_op(2, -16'sd100, 16'd7);
        expect_resp(4'b0100, -16'sd14, -16'sd2, 1'b0);
        Req = 4'b0100;
        collect(1, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL signed_resp got %h want %h", o, e); end
        end
        exp_ack.delete(); obs_ack.delete(); obs_q.delete();
    endtask

    task automatic test_round_robin();
        resp_t e, o;
        logic [3:0] ea, oa;
        reset_dut();
        set_op(0, 16'd50, 16'd3);
        set_op(1, -16'sd37, 16'd5);
        set_op(2, 16'd1000, -16'sd9);
        set_op(3, -16'sd8, -16'sd8);
        expect_resp(4'b0001, 16'd16, 16'd2, 1'b0);
        expect_resp(4'b0010, -16'sd7, -16'sd2, 1'b0);
        expect_resp(4'b0100, -16'sd111, 16'd1, 1'b0);
        expect_resp(4'b1000, 16'd1, 16'd0, 1'b0);
        Req = 4'b1111;
        collect(4, 300);
        while (exp_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = (obs_ack.size() > 0) ? obs_ack.pop_front() : 4'bxxxx;
            n_vec++; if (oa !== ea) begin n_err++; $display("FAIL rr_ack got %b want %b", oa, ea); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL rr_resp got %h want %h", o, e); end
        end
        obs_ack.delete(); obs_q.delete();
    endtask

    task automatic test_zero_div();
        resp_t e, o;
        set_op(1, 16'd55, 16'd0);
        expect_resp(4'b0010, 16'd0, 16'd55, 1'b1);
        Req = 4'b0010;
        collect(1, 50);
        repeat (3) @(negedge Clock);
        n_vec++; if (start_cycles != 0) begin n_err++; $display("FAIL zero_div_start got %0d cycles want 0", start_cycles); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL zero_div_resp got %h want %h", o, e); end
        end
        n_vec++; if ({Resp_Quotient, Resp_Remainder, Resp_Err} !== {16'd0, 16'd55, 1'b1}) begin
            n_err++; $display("FAIL zero_div_hold got q=%h r=%h e=%b want 0/0037/1", Resp_Quotient, Resp_Remainder, Resp_Err);
        end
        exp_ack.delete(); obs_ack.delete(); obs_q.delete();
    endtask

    task automatic test_timeout();
        resp_t e, o;
        never_done = 1'b1;
        set_op(0, 16'd9, 16'd3);
        // Quotient/remainder keep the previous response (zero-divisor case) on timeout.
        expect_resp(4'b0001, 16'd0, 16'd55, 1'b1);
        Req = 4'b0001;
        collect(1, 100);
        @(negedge Clock);
        n_vec++; if (start_cycles != 8) begin n_err++; $display("FAIL timeout_start got %0d cycles want 8", start_cycles); end
        n_vec++; if (Busy !== 1'b0) begin n_err++; $display("FAIL timeout_idle busy got %b want 0", Busy); end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL timeout_resp got %h want %h", o, e); end
        end
        never_done = 1'b0;
        exp_ack.delete(); obs_ack.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid();
        resp_t e, o;
        logic [3:0] ea, oa;
        int stray = 0;
        never_done = 1'b1;
        set_op(1, 16'd20, 16'd4);
        Req = 4'b0010;
        repeat (4) begin
            @(negedge Clock);
            Req = Req & ~Ack;
        end
        n_vec++; if ({Busy, Div_Start} !== 2'b11) begin n_err++; $display("FAIL mid_in_issue got %b want 11", {Busy, Div_Start}); end
        Reset = 1'b0;
        @(negedge Clock);
        n_vec++; if ({Busy, Div_Start} !== 2'b00) begin n_err++; $display("FAIL mid_reset got %b want 00", {Busy, Div_Start}); end
        Reset = 1'b1;
        never_done = 1'b0;
        repeat (12) begin
            @(negedge Clock);
            if (Resp_Valid != 4'd0) stray++;
        end
        n_vec++; if (stray != 0) begin n_err++; $display("FAIL mid_no_resp got %0d pulses want 0", stray); end
        // Ptr back at 0: requester 0 must precede requester 3.
        set_op(0, 16'd12, 16'd5);
        set_op(3, -16'sd7, 16'd2);
        expect_resp(4'b0001, 16'd2, 16'd2, 1'b0);
        expect_resp(4'b1000, -16'sd3, -16'sd1, 1'b0);
        Req = 4'b1001;
        collect(2, 200);
        while (exp_ack.size() > 0) begin
            ea = exp_ack.pop_front(); oa = (obs_ack.size() > 0) ? obs_ack.pop_front() : 4'bxxxx;
            n_vec++; if (oa !== ea) begin n_err++; $display("FAIL mid_next_ack got %b want %b", oa, ea); end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = (obs_q.size() > 0) ? obs_q.pop_front() : 'x;
            n_vec++; if (o !== e) begin n_err++; $display("FAIL mid_next_resp got %h want %h", o, e); end
        end
        obs_ack.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_round_robin();
        test_zero_div();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
